sayuru_nway_wt: RTL

SAYURU_NWAY_WT -- requirements
Module: sayuru_nway_wt

---
 rtl/sayuru_pkg.sv | 15 +
 rtl/sayuru_way_select.sv | 25 ++
 rtl/sayuru_nway_wt.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sayuru_pkg.sv
// rtl/sayuru_pkg.sv - shared types and constants for the sayuru write-through cache
package sayuru_pkg;

    localparam int COUNTER_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        RESP,
        FLUSH
    } state_e;

endpackage

// File: rtl/sayuru_way_select.sv
// rtl/sayuru_way_select.sv - victim way picker: lowest invalid way, else the set's round-robin pointer
module sayuru_way_select
    import sayuru_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]  valid_i,
    input  logic [WAY_W-1:0] rr_ptr_i,
    output logic [WAY_W-1:0] way_o,
    output logic             all_valid_o
);

    always_comb begin
        way_o       = rr_ptr_i;
        all_valid_o = &valid_i;
        // Walk downwards so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                way_o = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/sayuru_nway_wt.sv
// rtl/sayuru_nway_wt.sv - N-way set-associative write-through, no-write-allocate data cache
module sayuru_nway_wt
    import sayuru_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       in_data_req_i,
    output logic                       in_data_gnt_o,
    output logic                       in_data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]      in_data_addr_i,
    input  logic                       in_data_we_i,
    input  logic [DATA_WIDTH/8-1:0]    in_data_be_i,
    output logic [DATA_WIDTH-1:0]      in_data_rdata_o,
    input  logic [DATA_WIDTH-1:0]      in_data_wdata_i,

    output logic                       out_data_req_o,
    input  logic                       out_data_gnt_i,
    input  logic                       out_data_rvalid_i,
    output logic [ADDR_WIDTH-1:0]      out_data_addr_o,
    output logic                       out_data_we_o,
    output logic [DATA_WIDTH/8-1:0]    out_data_be_o,
    input  logic [DATA_WIDTH-1:0]      out_data_rdata_i,
    output logic [DATA_WIDTH-1:0]      out_data_wdata_o,

    input  logic                       flush_i,
    output logic                       flush_busy_o,

    output logic [COUNTER_WIDTH-1:0]   trans_count,
    output logic [COUNTER_WIDTH-1:0]   hit_load_count,
    output logic [COUNTER_WIDTH-1:0]   hit_store_count,
    output logic [COUNTER_WIDTH-1:0]   miss_load_count,
    output logic [COUNTER_WIDTH-1:0]   miss_store_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
    localparam int BE_W  = DATA_WIDTH / 8;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     we_q, we_d;
    logic [BE_W-1:0]          be_q, be_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     rvalid_q, rvalid_d;
    logic                     out_req_q, out_req_d;
    logic                     out_we_q, out_we_d;
    logic [ADDR_WIDTH-1:0]    out_addr_q, out_addr_d;
    logic [BE_W-1:0]          out_be_q, out_be_d;
    logic [DATA_WIDTH-1:0]    out_wdata_q, out_wdata_d;
    logic                     flush_busy_q, flush_busy_d;
    logic [COUNTER_WIDTH-1:0] trans_q, trans_d;
    logic [COUNTER_WIDTH-1:0] hit_ld_q, hit_ld_d;
    logic [COUNTER_WIDTH-1:0] hit_st_q, hit_st_d;
    logic [COUNTER_WIDTH-1:0] miss_ld_q, miss_ld_d;
    logic [COUNTER_WIDTH-1:0] miss_st_q, miss_st_d;

    logic [WAYS-1:0]          valid_q [SETS];
    logic [WAY_W-1:0]         rr_q    [SETS];
    logic [TAG_W-1:0]         tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0]    data_q  [SETS][WAYS];

    logic [IDX_W-1:0]         lk_idx;
    logic [TAG_W-1:0]         lk_tag;
    logic                     hit;
    logic [WAY_W-1:0]         hit_way;
    logic [WAY_W-1:0]         victim;
    logic                     all_valid;
    logic                     gnt;
    logic                     fill_en;
    logic                     merge_en;
    logic                     flush_en;

    // Lookup always works on the captured address; only one transaction is ever in flight.
    assign lk_idx = addr_q[2 +: IDX_W];
    assign lk_tag = addr_q[ADDR_WIDTH-1 -: TAG_W];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    sayuru_way_select #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_way_select (
        .valid_i     (valid_q[lk_idx]),
        .rr_ptr_i    (rr_q[lk_idx]),
        .way_o       (victim),
        .all_valid_o (all_valid)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        out_req_d    = out_req_q;
        out_we_d     = out_we_q;
        out_addr_d   = out_addr_q;
        out_be_d     = out_be_q;
        out_wdata_d  = out_wdata_q;
        flush_busy_d = 1'b0;
        trans_d      = trans_q;
        hit_ld_d     = hit_ld_q;
        hit_st_d     = hit_st_q;
        miss_ld_d    = miss_ld_q;
        miss_st_d    = miss_st_q;
        gnt          = 1'b0;
        fill_en      = 1'b0;
        merge_en     = 1'b0;
        flush_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d      = FLUSH;
                    flush_busy_d = 1'b1;
                end else if (in_data_req_i) begin
                    gnt     = 1'b1;
                    addr_d  = in_data_addr_i;
                    we_d    = in_data_we_i;
                    be_d    = in_data_be_i;
                    wdata_d = in_data_wdata_i;
                    trans_d = trans_q + 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    if (hit) hit_st_d = hit_st_q + 1'b1;
                    else     miss_st_d = miss_st_q + 1'b1;
                end else begin
                    if (hit) hit_ld_d = hit_ld_q + 1'b1;
                    else     miss_ld_d = miss_ld_q + 1'b1;
                end
                if (!we_q && hit) begin
                    rdata_d  = data_q[lk_idx][hit_way];
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    out_req_d   = 1'b1;
                    out_we_d    = we_q;
                    out_addr_d  = we_q ? addr_q : {addr_q[ADDR_WIDTH-1:2], 2'b00};
                    out_be_d    = we_q ? be_q : '1;
                    out_wdata_d = wdata_q;
                    state_d     = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (out_data_gnt_i) begin
                    out_req_d = 1'b0;
                    state_d   = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (out_data_rvalid_i) begin
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                    if (we_q) begin
                        merge_en = hit;
                    end else begin
                        rdata_d = out_data_rdata_i;
                        fill_en = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            FLUSH: begin
                flush_en = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            out_req_q    <= 1'b0;
            out_we_q     <= 1'b0;
            out_addr_q   <= '0;
            out_be_q     <= '0;
            out_wdata_q  <= '0;
            flush_busy_q <= 1'b0;
            trans_q      <= '0;
            hit_ld_q     <= '0;
            hit_st_q     <= '0;
            miss_ld_q    <= '0;
            miss_st_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            out_req_q    <= out_req_d;
            out_we_q     <= out_we_d;
            out_addr_q   <= out_addr_d;
            out_be_q     <= out_be_d;
            out_wdata_q  <= out_wdata_d;
            flush_busy_q <= flush_busy_d;
            trans_q      <= trans_d;
            hit_ld_q     <= hit_ld_d;
            hit_st_q     <= hit_st_d;
            miss_ld_q    <= miss_ld_d;
            miss_st_q    <= miss_st_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (flush_en) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (fill_en) begin
            valid_q[lk_idx][victim] <= 1'b1;
            if (all_valid) begin
                rr_q[lk_idx] <= (WAYS == 1) ? '0 : rr_q[lk_idx] + 1'b1;
            end
        end
    end

    // Tags and data need no reset: they are only ever observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[lk_idx][victim]  <= lk_tag;
            data_q[lk_idx][victim] <= out_data_rdata_i;
        end else if (merge_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_q[b]) begin
                    data_q[lk_idx][hit_way][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign in_data_gnt_o    = gnt;
    assign in_data_rvalid_o = rvalid_q;
    assign in_data_rdata_o  = rdata_q;
    assign out_data_req_o   = out_req_q;
    assign out_data_we_o    = out_we_q;
    assign out_data_addr_o  = out_addr_q;
    assign out_data_be_o    = out_be_q;
    assign out_data_wdata_o = out_wdata_q;
    assign flush_busy_o     = flush_busy_q;
    assign trans_count      = trans_q;
    assign hit_load_count   = hit_ld_q;
    assign hit_store_count  = hit_st_q;
    assign miss_load_count  = miss_ld_q;
    assign miss_store_count = miss_st_q;

endmodule
